// File: rtl/hs_unit_pkg.sv
// Purpose: shared constants and helpers for the handshaked pipeline units.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: HS_PIPE_DEPTH_MAX (upper bound on pipeline depth) and
//           hs_occ_width(depth) (bits needed to count 0..depth beats).
package hs_unit_pkg;

  localparam int HS_PIPE_DEPTH_MAX = 64;

  // Width of a counter that must represent every value from 0 to depth inclusive.
  function automatic int hs_occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hs_unit_pipe_stage.sv
// Purpose: one valid/data register stage of the handshaked pipeline.
// Latency: 1 cycle from load to visible on o_vld/o_dat.
// Backpressure: loads only when empty or when the next stage is ready, otherwise holds.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset (clears valid only)
//   flush      clears the valid bit next cycle
//   i_vld/i_dat  beat offered by the previous stage (or the pipe input)
//   i_nxt_rdy  ready of the stage downstream (out_ready for the last stage)
//   o_vld/o_dat  registered beat held by this stage
module hs_unit_pipe_stage
  import hs_unit_pkg::*;
#(
  parameter type DATA_TYPE = logic
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     i_vld,
  input  DATA_TYPE i_dat,
  input  logic     i_nxt_rdy,
  output logic     o_vld,
  output DATA_TYPE o_dat
);

  logic     r_vld;
  DATA_TYPE r_dat;
  logic     w_rdy;

  // An empty stage can always take a beat, which is what collapses bubbles.
  assign w_rdy = !r_vld || i_nxt_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
    end else if (flush) begin
      r_vld <= 1'b0;
    end else if (w_rdy) begin
      r_vld <= i_vld;
    end
  end

  // Payload has no reset and is only written for a real incoming beat.
  always_ff @(posedge clk) begin
    if (w_rdy && i_vld) begin
      r_dat <= i_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/hs_unit_pipe_reg.sv
// Purpose: DEPTH-stage valid/ready pipeline register for retiming between streaming units.
// Latency: DEPTH cycles from input handshake to out_valid when unstalled; 1 beat/cycle.
// Backpressure: out_ready ripples combinationally to in_ready; empty stages absorb bubbles.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   flush               drops every in-flight beat; in_ready is 0 that cycle
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake (out_data undefined when !out_valid)
//   occupancy           count of valid stages; only with HS_UNIT_PIPE_OCC_EN defined
module hs_unit_pipe_reg
  import hs_unit_pkg::*;
#(
  parameter type DATA_TYPE = logic,
  parameter int  DEPTH     = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  DATA_TYPE in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output DATA_TYPE out_data
`ifdef HS_UNIT_PIPE_OCC_EN
  ,
  output logic [hs_occ_width(DEPTH)-1:0] occupancy
`endif
);

  if (DEPTH < 1 || DEPTH > HS_PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("hs_unit_pipe_reg: DEPTH %0d outside 1..%0d", DEPTH, HS_PIPE_DEPTH_MAX);
  end

  logic [DEPTH-1:0] w_vld;
  logic [DEPTH:0]   w_rdy;
  DATA_TYPE         w_dat [DEPTH];

  assign w_rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic     w_in_vld;
    DATA_TYPE w_in_dat;

    // Stage i is ready when out_ready is high or any stage from i to the
    // end is empty. This is the unrolled form of rdy[i] = !vld[i] || rdy[i+1]
    // and keeps the ready vector free of self-dependence.
    assign w_rdy[i] = out_ready || !(&w_vld[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign w_in_vld = in_valid && !flush;
      assign w_in_dat = in_data;
    end else begin : g_body
      assign w_in_vld = w_vld[i-1];
      assign w_in_dat = w_dat[i-1];
    end

    hs_unit_pipe_stage #(
      .DATA_TYPE(DATA_TYPE)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .i_vld    (w_in_vld),
      .i_dat    (w_in_dat),
      .i_nxt_rdy(w_rdy[i+1]),
      .o_vld    (w_vld[i]),
      .o_dat    (w_dat[i])
    );
  end

  assign in_ready  = w_rdy[0] && !flush;
  assign out_valid = w_vld[DEPTH-1];
  assign out_data  = w_dat[DEPTH-1];

`ifdef HS_UNIT_PIPE_OCC_EN
  localparam int OCC_W = hs_occ_width(DEPTH);

  logic [OCC_W-1:0] r_occ;
  logic             w_in_hs;
  logic             w_out_hs;

  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;

  // Tracks popcount of the valid bits; a simultaneous accept and emit cancels.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= '0;
    end else if (w_in_hs && !w_out_hs) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_in_hs && w_out_hs) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_hs_unit_pipe_reg.sv
// Purpose: self-checking bench for hs_unit_pipe_reg at DEPTH 1..4 sharing one stimulus stream.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
// Reference model: per depth, a FIFO of {data, accept cycle}; the head is visible
// once DEPTH cycles have passed since its acceptance, and the pipe accepts
// whenever it is not full or out_ready is high (and flush is low).
module tb_hs_unit_pipe_reg;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       ov [4];
  logic       ir [4];
  logic [7:0] od [4];
`ifdef HS_UNIT_PIPE_OCC_EN
  int         occ_v [4];
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
`ifdef HS_UNIT_PIPE_OCC_EN
    logic [$clog2(g+2)-1:0] w_occ;
    assign occ_v[g] = int'(w_occ);
`endif
    hs_unit_pipe_reg #(
      .DATA_TYPE(logic [7:0]),
      .DEPTH    (g + 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .in_data  (in_data),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_data (od[g])
`ifdef HS_UNIT_PIPE_OCC_EN
      ,
      .occupancy(w_occ)
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks;
  int         errors;
  int         cyc;
  logic       model_on;
  logic [7:0] mq_d [4][$];
  int         mq_t [4][$];
  logic       snap_ov [4];
  logic       snap_ir [4];
  logic [7:0] snap_od [4];
`ifdef HS_UNIT_PIPE_OCC_EN
  int         snap_occ [4];
`endif

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       o;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ir;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s depth=%0d cycle=%0d actual=%h expected=%h", nm, k + 1, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every DUT with the model mid-cycle,
  // then advance the model across the rising edge.
  task automatic step(input logic r, input logic f, input logic v, input logic [7:0] d, input logic o);
    logic e_ov [4];
    logic e_ir [4];
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_data   = d;
    out_ready = o;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      e_ov[k] = (mq_d[k].size() > 0) && ((cyc - mq_t[k][0]) >= (k + 1));
      e_ir[k] = ((mq_d[k].size() < (k + 1)) || o) && !f;
      snap_ov[k] = ov[k];
      snap_ir[k] = ir[k];
      snap_od[k] = od[k];
`ifdef HS_UNIT_PIPE_OCC_EN
      snap_occ[k] = occ_v[k];
`endif
      if (model_on) begin
        chk("model_out_valid", k, 32'(ov[k]), 32'(e_ov[k]));
        chk("model_in_ready", k, 32'(ir[k]), 32'(e_ir[k]));
        if (e_ov[k]) chk("model_out_data", k, 32'(od[k]), 32'(mq_d[k][0]));
`ifdef HS_UNIT_PIPE_OCC_EN
        chk("model_occupancy", k, occ_v[k], mq_d[k].size());
`endif
      end
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (r) begin
        mq_d[k].delete();
        mq_t[k].delete();
      end else begin
        if (e_ov[k] && o) begin
          void'(mq_d[k].pop_front());
          void'(mq_t[k].pop_front());
        end
        if (f) begin
          mq_d[k].delete();
          mq_t[k].delete();
        end else if (v && e_ir[k]) begin
          mq_d[k].push_back(d);
          mq_t[k].push_back(cyc);
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    model_on  = 1'b0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;

    // DEPTH=4 backpressure fill then drain; expected values worked out by hand.
    tbl[0]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[2]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[3]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[4]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 8'hA0, 1'b0};
    tbl[5]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 8'hA0, 1'b0};
    tbl[6]  = '{1'b1, 8'hA4, 1'b1, 1'b1, 8'hA0, 1'b1};
    tbl[7]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA1, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};

    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    model_on = 1'b1;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("reset_out_valid", k, 32'(snap_ov[k]), 32'd0);
      chk("reset_in_ready", k, 32'(snap_ir[k]), 32'd1);
`ifdef HS_UNIT_PIPE_OCC_EN
      chk("reset_occupancy", k, snap_occ[k], 0);
`endif
    end

    // Table-driven backpressure fill/drain on DEPTH=4.
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b0, tbl[i].iv, tbl[i].d, tbl[i].o);
      chk("tbl_out_valid", 3, 32'(snap_ov[3]), 32'(tbl[i].e_ov));
      chk("tbl_in_ready", 3, 32'(snap_ir[3]), 32'(tbl[i].e_ir));
      if (tbl[i].e_ov) chk("tbl_out_data", 3, 32'(snap_od[3]), 32'(tbl[i].e_od));
    end
    idle(6);

    // Flush on DEPTH=3 with three beats in flight and a beat offered during flush.
    step(1'b0, 1'b0, 1'b1, 8'hB1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hB3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hB4, 1'b0);
    chk("flush_in_ready", 2, 32'(snap_ir[2]), 32'd0);
    chk("flush_out_valid_cur", 2, 32'(snap_ov[2]), 32'd1);
    chk("flush_out_data_cur", 2, 32'(snap_od[2]), 32'hB1);
`ifdef HS_UNIT_PIPE_OCC_EN
    chk("flush_occ_before", 2, snap_occ[2], 3);
`endif
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("flush_out_valid_after", 2, 32'(snap_ov[2]), 32'd0);
`ifdef HS_UNIT_PIPE_OCC_EN
      chk("flush_occ_after", 2, snap_occ[2], 0);
`endif
    end

    // Reset mid-stream on a full DEPTH=2 pipe.
    step(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hC2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'hC3, 1'b0);
    chk("full_in_ready", 1, 32'(snap_ir[1]), 32'd0);
    chk("full_out_data", 1, 32'(snap_od[1]), 32'hC1);
    step(1'b0, 1'b0, 1'b1, 8'h77, 1'b1);
    chk("post_rst_out_valid", 1, 32'(snap_ov[1]), 32'd0);
    chk("post_rst_in_ready", 1, 32'(snap_ir[1]), 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rst_lat1", 1, 32'(snap_ov[1]), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rst_lat2_vld", 1, 32'(snap_ov[1]), 32'd1);
    chk("post_rst_lat2_dat", 1, 32'(snap_od[1]), 32'h77);
    idle(6);

    // Streaming on DEPTH=3: 0x01..0x10 back to back, no stalls.
    for (int j = 0; j < 19; j++) begin
      step(1'b0, 1'b0, (j < 16), 8'(j + 1), 1'b1);
      chk("stream_out_valid", 2, 32'(snap_ov[2]), 32'((j >= 3) && (j < 19)));
      if (j >= 3) chk("stream_out_data", 2, 32'(snap_od[2]), 32'(j - 2));
`ifdef HS_UNIT_PIPE_OCC_EN
      if (j >= 3 && j < 16) chk("stream_occ", 2, snap_occ[2], 3);
`endif
    end
    idle(6);

    // DEPTH=1 with out_ready toggling 1,0,1 under continuous input.
    for (int j = 0; j < 12; j++) begin
      step(1'b0, 1'b0, 1'b1, 8'(8'hD0 + j), ((j % 3) != 1));
`ifdef HS_UNIT_PIPE_OCC_EN
      chk("d1_occ_bound", 0, 32'(snap_occ[0] <= 1), 32'd1);
`endif
    end
    idle(6);

    // Bubble collapse on DEPTH=4.
    step(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("bubble_vld", 3, 32'(snap_ov[3]), 32'd1);
    chk("bubble_head", 3, 32'(snap_od[3]), 32'h55);
    chk("bubble_in_ready", 3, 32'(snap_ir[3]), 32'd1);
`ifdef HS_UNIT_PIPE_OCC_EN
    chk("bubble_occ", 3, snap_occ[3], 2);
`endif
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("bubble_first", 3, 32'(snap_od[3]), 32'h55);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("bubble_second_vld", 3, 32'(snap_ov[3]), 32'd1);
    chk("bubble_second", 3, 32'(snap_od[3]), 32'h66);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("bubble_empty", 3, 32'(snap_ov[3]), 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(199) == 0), ($urandom_range(49) == 0),
           ($urandom_range(9) < 7), 8'($urandom), ($urandom_range(9) < 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
